// File: rtl/cache_types.sv
// cache_types: FSM states and cache geometry shared by the cache controller and datapath.
package cache_types;

    localparam int s_offset = 5;
    localparam int s_index  = 3;
    localparam int s_tag    = 32 - s_index - s_offset;
    localparam int s_line   = 256;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

endpackage

// File: rtl/cache_control.sv
// cache_control: miss/hit sequencing FSM for the 2-way write-back, write-allocate L1 cache.
module cache_control
    import cache_types::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       mem_resp,
    input  logic [1:0] hit,
    input  logic [1:0] valid,
    input  logic [1:0] dirty,
    input  logic       lru,
    output logic       way_sel,
    output logic       load_data,
    output logic       data_sel,
    output logic       load_tag,
    output logic       load_valid,
    output logic       load_dirty,
    output logic       dirty_in,
    output logic       load_lru,
    output logic       lru_in,
    output logic       paddr_sel,
    output logic       pmem_read,
    output logic       pmem_write,
    input  logic       pmem_resp
);

    state_t state, state_next;
    logic   req, any_hit, victim_dirty;

    assign req          = mem_read | mem_write;
    assign any_hit      = |hit;
    assign victim_dirty = valid[lru] & dirty[lru];

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = (req && !any_hit) ? (victim_dirty ? WRITEBACK : FILL) : IDLE;
            WRITEBACK: state_next = pmem_resp ? FILL : WRITEBACK;
            FILL:      state_next = pmem_resp ? IDLE : FILL;
            default:   state_next = IDLE;
        endcase
    end

    // A fill only refreshes the line; the request then completes as an ordinary hit.
    always_comb begin
        mem_resp   = 1'b0;
        way_sel    = 1'b0;
        load_data  = 1'b0;
        data_sel   = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        dirty_in   = 1'b0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        paddr_sel  = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (req && any_hit) begin
                    mem_resp   = 1'b1;
                    way_sel    = hit[1];
                    load_lru   = 1'b1;
                    lru_in     = ~hit[1];
                    load_data  = mem_write;
                    load_dirty = mem_write;
                    dirty_in   = mem_write;
                end else if (req) begin
                    way_sel = lru;
                end
            end
            WRITEBACK: begin
                way_sel    = lru;
                paddr_sel  = 1'b1;
                pmem_write = 1'b1;
            end
            FILL: begin
                way_sel    = lru;
                pmem_read  = 1'b1;
                load_data  = pmem_resp;
                data_sel   = pmem_resp;
                load_tag   = pmem_resp;
                load_valid = pmem_resp;
                load_dirty = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: table vectors, hand-written miss sequences and randomized checks against a transaction model.
module tb_cache_control;

    typedef struct packed {
        logic mem_resp;
        logic way_sel;
        logic load_data;
        logic data_sel;
        logic load_tag;
        logic load_valid;
        logic load_dirty;
        logic dirty_in;
        logic load_lru;
        logic lru_in;
        logic paddr_sel;
        logic pmem_read;
        logic pmem_write;
    } outs_t;

    typedef struct {
        string      name;
        logic       rd;
        logic       wr;
        logic [1:0] hit;
        logic       lru;
        logic       resp;
        outs_t      exp;
    } vec_t;

    localparam int PH_IDLE = 0;
    localparam int PH_WB   = 1;
    localparam int PH_FILL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b0, mem_write = 1'b0, mem_resp;
    logic [1:0] hit = '0, valid = '0, dirty = '0;
    logic       lru = 1'b0, pmem_resp = 1'b0;
    logic       way_sel, load_data, data_sel, load_tag, load_valid, load_dirty, dirty_in;
    logic       load_lru, lru_in, paddr_sel, pmem_read, pmem_write;
    outs_t      act;
    int         tests = 0;
    int         fails = 0;

    cache_control dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .valid(valid), .dirty(dirty), .lru(lru), .way_sel(way_sel),
        .load_data(load_data), .data_sel(data_sel), .load_tag(load_tag), .load_valid(load_valid),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
        .paddr_sel(paddr_sel), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    assign act = {mem_resp, way_sel, load_data, data_sel, load_tag, load_valid, load_dirty,
                  dirty_in, load_lru, lru_in, paddr_sel, pmem_read, pmem_write};

    task automatic chk(input string name, input outs_t e);
        tests++;
        if (act !== e) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, e);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] h, input logic [1:0] v,
                         input logic [1:0] d, input logic l, input logic r);
        mem_read = rd; mem_write = wr; hit = h; valid = v; dirty = d; lru = l; pmem_resp = r;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: what a request phase must present, derived from the protocol rules.
    function automatic outs_t model_out(input int ph, input logic rd, input logic wr,
                                        input logic [1:0] h, input logic l, input logic r);
        outs_t o = '0;
        if (ph == PH_IDLE && (rd || wr) && h != 2'b00) begin
            o.mem_resp = 1; o.way_sel = h[1]; o.load_lru = 1; o.lru_in = !h[1];
            if (wr) begin o.load_data = 1; o.load_dirty = 1; o.dirty_in = 1; end
        end else if (ph == PH_IDLE && (rd || wr)) begin
            o.way_sel = l;
        end else if (ph == PH_WB) begin
            o.way_sel = l; o.paddr_sel = 1; o.pmem_write = 1;
        end else if (ph == PH_FILL) begin
            o.way_sel = l; o.pmem_read = 1;
            if (r) begin o.load_data = 1; o.data_sel = 1; o.load_tag = 1; o.load_valid = 1; o.load_dirty = 1; end
        end
        return o;
    endfunction

    function automatic int model_next(input int ph, input logic rd, input logic wr, input logic [1:0] h,
                                      input logic [1:0] v, input logic [1:0] d, input logic l, input logic r);
        if (ph == PH_IDLE) return ((rd || wr) && h == 2'b00) ? ((v[l] && d[l]) ? PH_WB : PH_FILL) : PH_IDLE;
        if (ph == PH_WB) return r ? PH_FILL : PH_WB;
        return r ? PH_IDLE : PH_FILL;
    endfunction

    vec_t  vecs[6];
    outs_t fill_done;
    int    ph;

    initial begin
        fill_done = '{pmem_read: 1, load_data: 1, data_sel: 1, load_tag: 1, load_valid: 1, load_dirty: 1, default: 0};
        vecs[0] = '{"idle_noreq",   0, 0, 2'b00, 1, 0, '{default: 0}};
        vecs[1] = '{"read_hit_w1",  1, 0, 2'b10, 0, 0, '{mem_resp: 1, way_sel: 1, load_lru: 1, default: 0}};
        vecs[2] = '{"read_hit_w0",  1, 0, 2'b01, 0, 0, '{mem_resp: 1, load_lru: 1, lru_in: 1, default: 0}};
        vecs[3] = '{"write_hit_w0", 0, 1, 2'b01, 1, 0, '{mem_resp: 1, load_data: 1, load_dirty: 1, dirty_in: 1, load_lru: 1, lru_in: 1, default: 0}};
        vecs[4] = '{"write_hit_w1", 0, 1, 2'b10, 0, 0, '{mem_resp: 1, way_sel: 1, load_data: 1, load_dirty: 1, dirty_in: 1, load_lru: 1, default: 0}};
        vecs[5] = '{"idle_stray_resp", 0, 0, 2'b00, 0, 1, '{default: 0}};

        rst = 1;
        tick; tick;
        drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("reset_outputs", '0);
        rst = 0;
        tick;
        chk("post_reset_idle", '0);

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].hit, 2'b11, 2'b00, vecs[i].lru, vecs[i].resp);
            chk(vecs[i].name, vecs[i].exp);
            tick;
        end

        drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("cold_miss_idle", '0);
        tick;
        for (int i = 0; i < 3; i++) begin
            chk("cold_fill_wait", '{pmem_read: 1, default: 0});
            tick;
        end
        drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 1);
        chk("cold_fill_done", fill_done);
        tick;
        drive(1, 0, 2'b01, 2'b01, 2'b00, 0, 0);
        chk("cold_complete", '{mem_resp: 1, load_lru: 1, lru_in: 1, default: 0});
        tick;

        drive(0, 1, 2'b00, 2'b11, 2'b11, 1, 0);
        chk("dirty_miss_idle", '{way_sel: 1, default: 0});
        tick;
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 2'b00, 2'b11, 2'b11, 1, i == 9);
            chk("writeback_hold", '{way_sel: 1, paddr_sel: 1, pmem_write: 1, default: 0});
            tick;
        end
        drive(0, 1, 2'b00, 2'b11, 2'b11, 1, 0);
        chk("dirty_fill_wait", '{way_sel: 1, pmem_read: 1, default: 0});
        tick;
        drive(0, 1, 2'b00, 2'b11, 2'b11, 1, 1);
        chk("dirty_fill_done", '{way_sel: 1, pmem_read: 1, load_data: 1, data_sel: 1, load_tag: 1, load_valid: 1, load_dirty: 1, default: 0});
        tick;
        drive(0, 1, 2'b10, 2'b11, 2'b01, 1, 0);
        chk("dirty_write_merge", '{mem_resp: 1, way_sel: 1, load_data: 1, load_dirty: 1, dirty_in: 1, load_lru: 1, default: 0});
        tick;

        drive(1, 0, 2'b00, 2'b11, 2'b01, 1, 0);
        chk("clean_victim_idle", '{way_sel: 1, default: 0});
        tick;
        chk("clean_victim_fill", '{way_sel: 1, pmem_read: 1, default: 0});
        drive(1, 0, 2'b00, 2'b11, 2'b01, 1, 1);
        tick;
        drive(0, 0, 2'b00, 2'b11, 2'b01, 1, 0);
        chk("clean_victim_back_idle", '0);
        tick;

        drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        tick;
        chk("rst_fill_active", '{pmem_read: 1, default: 0});
        rst = 1;
        tick;
        rst = 0;
        drive(0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rst_fill_dropped", '0);
        tick;
        drive(1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        chk("rst_restart_idle", '0);
        tick;
        chk("rst_restart_fill", '{pmem_read: 1, default: 0});

        rst = 1;
        tick;
        rst = 0;
        ph = PH_IDLE;
        for (int i = 0; i < 3000; i++) begin
            int k;
            logic r_rst;
            k = int'($urandom_range(0, 2));
            r_rst = ($urandom_range(0, 49) == 0);
            rst = r_rst;
            drive(k == 1, k == 2, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            chk("random", model_out(ph, mem_read, mem_write, hit, lru, pmem_resp));
            ph = r_rst ? PH_IDLE : model_next(ph, mem_read, mem_write, hit, valid, dirty, lru, pmem_resp);
            tick;
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
